// File: rtl/regfile_scoreboard_if.sv
// rtl/regfile_scoreboard_if.sv - decode/writeback bundle for the register file scoreboard
interface regfile_scoreboard_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
);
  logic [ADDR_W-1:0] read_address1;
  logic [ADDR_W-1:0] read_address2;
  logic [DATA_W-1:0] read_data1;
  logic [DATA_W-1:0] read_data2;
  logic              read_busy1;
  logic              read_busy2;
  logic              write_en_a;
  logic [ADDR_W-1:0] write_address_a;
  logic [DATA_W-1:0] write_data_a;
  logic              write_en_b;
  logic [ADDR_W-1:0] write_address_b;
  logic [DATA_W-1:0] write_data_b;
  logic              issue_en;
  logic [ADDR_W-1:0] issue_address;
  logic [ADDR_W-1:0] debug_address;
  logic [DATA_W-1:0] debug_data;
  logic [CNT_W-1:0]  write_count;

  modport master (
    output read_address1, read_address2, write_en_a, write_address_a, write_data_a,
           write_en_b, write_address_b, write_data_b, issue_en, issue_address, debug_address,
    input  read_data1, read_data2, read_busy1, read_busy2, debug_data, write_count
  );

  modport slave (
    input  read_address1, read_address2, write_en_a, write_address_a, write_data_a,
           write_en_b, write_address_b, write_data_b, issue_en, issue_address, debug_address,
    output read_data1, read_data2, read_busy1, read_busy2, debug_data, write_count
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - 2W/2R/1-debug register file with busy scoreboard and bypass
module regfile_scoreboard #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  parameter int CNT_W    = 16
) (
  input logic                 clk,
  input logic                 rst_n,
  regfile_scoreboard_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DATA_W-1:0] regs_d [DEPTH];
  logic [DEPTH-1:0]  busy_q, busy_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              we_a, we_b, store_a;
  logic [ADDR_W-1:0] ra [2];
  logic [DATA_W-1:0] rd [2];
  logic              rb [2];

  function automatic logic is_zero(input logic [ADDR_W-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  // Writes are suppressed while reset is held so reads reflect the zeroed array.
  always_comb begin
    we_a    = rst_n && bus.write_en_a && !is_zero(bus.write_address_a);
    we_b    = rst_n && bus.write_en_b && !is_zero(bus.write_address_b);
    store_a = we_a && !(we_b && (bus.write_address_a == bus.write_address_b));
  end

  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    if (store_a) begin
      regs_d[bus.write_address_a] = bus.write_data_a;
      busy_d[bus.write_address_a] = 1'b0;
    end
    if (we_b) begin
      regs_d[bus.write_address_b] = bus.write_data_b;
      busy_d[bus.write_address_b] = 1'b0;
    end
    // A new issue overrides a same-cycle writeback: the newer producer still owes a result.
    if (bus.issue_en && !is_zero(bus.issue_address)) begin
      busy_d[bus.issue_address] = 1'b1;
    end
    if (ZERO_REG != 0) begin
      busy_d[0] = 1'b0;
    end
    cnt_d = cnt_q + CNT_W'(store_a) + CNT_W'(we_b);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs_q <= '{default: '0};
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  always_comb begin
    logic hit_a;
    logic hit_b;
    logic byp;
    hit_a = 1'b0;
    hit_b = 1'b0;
    byp   = 1'b0;
    ra[0] = bus.read_address1;
    ra[1] = bus.read_address2;
    for (int p = 0; p < 2; p++) begin
      hit_a = we_a && (bus.write_address_a == ra[p]);
      hit_b = we_b && (bus.write_address_b == ra[p]);
      byp   = (BYPASS != 0) && (hit_a || hit_b);
      if (!byp) begin
        rd[p] = is_zero(ra[p]) ? '0 : regs_q[ra[p]];
      end else if (hit_b) begin
        rd[p] = bus.write_data_b;
      end else begin
        rd[p] = bus.write_data_a;
      end
      rb[p] = busy_q[ra[p]] && !byp;
    end
  end

  assign bus.read_data1  = rd[0];
  assign bus.read_data2  = rd[1];
  assign bus.read_busy1  = rb[0];
  assign bus.read_busy2  = rb[1];
  assign bus.debug_data  = is_zero(bus.debug_address) ? '0 : regs_q[bus.debug_address];
  assign bus.write_count = cnt_q;
endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb/tb_regfile_scoreboard.sv - scoreboard bench for regfile_scoreboard and its parameter variants
module tb_regfile_scoreboard;
  typedef struct {
    string       name;
    logic [31:0] val;
  } item_t;

  logic        clk;
  logic        rst_n;
  logic [4:0]  ra1, ra2, waa, wab, ia, da;
  logic [31:0] wda, wdb;
  logic        wea, web, ie;

  item_t       exp_q[$];
  logic [31:0] obs_q[$];
  int          n_cmp;
  int          n_bad;
  int unsigned cnt_exp;
  int unsigned cnt_z0_exp;

  regfile_scoreboard_if #(.DATA_W(32), .ADDR_W(5), .CNT_W(16)) i0 ();
  regfile_scoreboard_if #(.DATA_W(32), .ADDR_W(5), .CNT_W(16)) i1 ();
  regfile_scoreboard_if #(.DATA_W(32), .ADDR_W(5), .CNT_W(16)) i2 ();
  regfile_scoreboard_if #(.DATA_W(32), .ADDR_W(5), .CNT_W(4))  i3 ();

  assign {i0.read_address1, i1.read_address1, i2.read_address1, i3.read_address1} = {4{ra1}};
  assign {i0.read_address2, i1.read_address2, i2.read_address2, i3.read_address2} = {4{ra2}};
  assign {i0.write_en_a, i1.write_en_a, i2.write_en_a, i3.write_en_a} = {4{wea}};
  assign {i0.write_address_a, i1.write_address_a, i2.write_address_a, i3.write_address_a} = {4{waa}};
  assign {i0.write_data_a, i1.write_data_a, i2.write_data_a, i3.write_data_a} = {4{wda}};
  assign {i0.write_en_b, i1.write_en_b, i2.write_en_b, i3.write_en_b} = {4{web}};
  assign {i0.write_address_b, i1.write_address_b, i2.write_address_b, i3.write_address_b} = {4{wab}};
  assign {i0.write_data_b, i1.write_data_b, i2.write_data_b, i3.write_data_b} = {4{wdb}};
  assign {i0.issue_en, i1.issue_en, i2.issue_en, i3.issue_en} = {4{ie}};
  assign {i0.issue_address, i1.issue_address, i2.issue_address, i3.issue_address} = {4{ia}};
  assign {i0.debug_address, i1.debug_address, i2.debug_address, i3.debug_address} = {4{da}};

  regfile_scoreboard #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(1), .CNT_W(16))
    u_main (.clk(clk), .rst_n(rst_n), .bus(i0));
  regfile_scoreboard #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(0), .BYPASS(1), .CNT_W(16))
    u_z0 (.clk(clk), .rst_n(rst_n), .bus(i1));
  regfile_scoreboard #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(0), .CNT_W(16))
    u_nb (.clk(clk), .rst_n(rst_n), .bus(i2));
  regfile_scoreboard #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(1), .CNT_W(4))
    u_c4 (.clk(clk), .rst_n(rst_n), .bus(i3));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic void push_exp(input string n, input logic [31:0] v);
    item_t it;
    it.name = n;
    it.val  = v;
    exp_q.push_back(it);
  endfunction

  task automatic idle();
    wea = 1'b0; web = 1'b0; ie = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    item_t e;
    logic [31:0] o;
    step();
    wea = 1'b1; waa = 5'd3; wda = 32'h77;
    ie = 1'b1; ia = 5'd4;
    step();
    idle();
    ra1 = 5'd3; ra2 = 5'd4; da = 5'd3;
    push_exp("rst_pre_dbg", 32'h77);
    push_exp("rst_pre_busy", 32'd1);
    @(negedge clk);
    obs_q.push_back(i0.debug_data);
    obs_q.push_back(32'(i0.read_busy2));
    wea = 1'b1; waa = 5'd5; wda = 32'h55; ra2 = 5'd5;
    #1 rst_n = 1'b0;
    #1;
    push_exp("rst_rd1", 32'd0);
    push_exp("rst_rd2_wr_pending", 32'd0);
    push_exp("rst_dbg", 32'd0);
    push_exp("rst_cnt", 32'd0);
    push_exp("rst_cnt_z0", 32'd0);
    obs_q.push_back(i0.read_data1);
    obs_q.push_back(i0.read_data2);
    obs_q.push_back(i0.debug_data);
    obs_q.push_back(32'(i0.write_count));
    obs_q.push_back(32'(i1.write_count));
    ra2 = 5'd4;
    #1;
    push_exp("rst_busy", 32'd0);
    obs_q.push_back(32'(i0.read_busy2));
    step();
    push_exp("rst_hold_cnt", 32'd0);
    obs_q.push_back(32'(i0.write_count));
    idle();
    rst_n = 1'b1;
    cnt_exp = 0;
    cnt_z0_exp = 0;
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (obs_q.size() == 0) begin
        n_bad++;
        $display("FAIL %s: no sample, expected %h", e.name, e.val);
      end else begin
        o = obs_q.pop_front();
        if (o !== e.val) begin
          n_bad++;
          $display("FAIL %s: got %h expected %h", e.name, o, e.val);
        end
      end
    end
  endtask

  task automatic test_write_read();
    item_t e;
    logic [31:0] o;
    step();
    wea = 1'b1; waa = 5'd8; wda = 32'hDEADBEEF; ra1 = 5'd8; da = 5'd8;
    push_exp("wr_bypass_rd1", 32'hDEADBEEF);
    push_exp("wr_dbg_before", 32'd0);
    push_exp("wr_nobypass_rd1", 32'd0);
    push_exp("wr_cnt_before", 32'(cnt_exp));
    @(negedge clk);
    obs_q.push_back(i0.read_data1);
    obs_q.push_back(i0.debug_data);
    obs_q.push_back(i2.read_data1);
    obs_q.push_back(32'(i0.write_count));
    step();
    idle();
    cnt_exp++; cnt_z0_exp++;
    push_exp("wr_dbg_after", 32'hDEADBEEF);
    push_exp("wr_cnt_after", 32'(cnt_exp));
    push_exp("wr_nobypass_after", 32'hDEADBEEF);
    @(negedge clk);
    obs_q.push_back(i0.debug_data);
    obs_q.push_back(32'(i0.write_count));
    obs_q.push_back(i2.read_data1);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (obs_q.size() == 0) begin
        n_bad++;
        $display("FAIL %s: no sample, expected %h", e.name, e.val);
      end else begin
        o = obs_q.pop_front();
        if (o !== e.val) begin
          n_bad++;
          $display("FAIL %s: got %h expected %h", e.name, o, e.val);
        end
      end
    end
  endtask

  task automatic test_collision();
    item_t e;
    logic [31:0] o;
    step();
    wea = 1'b1; waa = 5'd10; wda = 32'h11;
    web = 1'b1; wab = 5'd10; wdb = 32'h22;
    ra2 = 5'd10; da = 5'd10;
    push_exp("col_bypass_rd2", 32'h22);
    @(negedge clk);
    obs_q.push_back(i0.read_data2);
    step();
    idle();
    cnt_exp++; cnt_z0_exp++;
    push_exp("col_stored", 32'h22);
    push_exp("col_cnt", 32'(cnt_exp));
    @(negedge clk);
    obs_q.push_back(i0.debug_data);
    obs_q.push_back(32'(i0.write_count));
    step();
    wea = 1'b1; waa = 5'd12; wda = 32'h33;
    web = 1'b1; wab = 5'd13; wdb = 32'h44;
    ra1 = 5'd12; ra2 = 5'd13;
    push_exp("dual_rd1", 32'h33);
    push_exp("dual_rd2", 32'h44);
    @(negedge clk);
    obs_q.push_back(i0.read_data1);
    obs_q.push_back(i0.read_data2);
    step();
    idle();
    cnt_exp += 2; cnt_z0_exp += 2;
    push_exp("dual_cnt", 32'(cnt_exp));
    push_exp("dual_nb_rd1", 32'h33);
    @(negedge clk);
    obs_q.push_back(32'(i0.write_count));
    obs_q.push_back(i2.read_data1);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (obs_q.size() == 0) begin
        n_bad++;
        $display("FAIL %s: no sample, expected %h", e.name, e.val);
      end else begin
        o = obs_q.pop_front();
        if (o !== e.val) begin
          n_bad++;
          $display("FAIL %s: got %h expected %h", e.name, o, e.val);
        end
      end
    end
  endtask

  task automatic test_zero_reg();
    item_t e;
    logic [31:0] o;
    step();
    wea = 1'b1; waa = 5'd0; wda = 32'h5;
    ie = 1'b1; ia = 5'd0;
    ra1 = 5'd0; da = 5'd0;
    push_exp("r0_rd1_same", 32'd0);
    push_exp("r0_z0_rd1_same", 32'h5);
    @(negedge clk);
    obs_q.push_back(i0.read_data1);
    obs_q.push_back(i1.read_data1);
    step();
    idle();
    cnt_z0_exp++;
    push_exp("r0_rd1", 32'd0);
    push_exp("r0_cnt", 32'(cnt_exp));
    push_exp("r0_busy", 32'd0);
    push_exp("r0_z0_rd1", 32'h5);
    push_exp("r0_z0_dbg", 32'h5);
    push_exp("r0_z0_cnt", 32'(cnt_z0_exp));
    push_exp("r0_z0_busy", 32'd1);
    @(negedge clk);
    obs_q.push_back(i0.read_data1);
    obs_q.push_back(32'(i0.write_count));
    obs_q.push_back(32'(i0.read_busy1));
    obs_q.push_back(i1.read_data1);
    obs_q.push_back(i1.debug_data);
    obs_q.push_back(32'(i1.write_count));
    obs_q.push_back(32'(i1.read_busy1));
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (obs_q.size() == 0) begin
        n_bad++;
        $display("FAIL %s: no sample, expected %h", e.name, e.val);
      end else begin
        o = obs_q.pop_front();
        if (o !== e.val) begin
          n_bad++;
          $display("FAIL %s: got %h expected %h", e.name, o, e.val);
        end
      end
    end
  endtask

  task automatic test_scoreboard();
    item_t e;
    logic [31:0] o;
    step();
    ie = 1'b1; ia = 5'd11; ra1 = 5'd11;
    push_exp("sb_busy_before", 32'd0);
    @(negedge clk);
    obs_q.push_back(32'(i0.read_busy1));
    step();
    idle();
    push_exp("sb_busy_set", 32'd1);
    @(negedge clk);
    obs_q.push_back(32'(i0.read_busy1));
    step();
    web = 1'b1; wab = 5'd11; wdb = 32'h99;
    push_exp("sb_busy_masked", 32'd0);
    push_exp("sb_rd1_bypass", 32'h99);
    push_exp("sb_nb_busy_unmasked", 32'd1);
    @(negedge clk);
    obs_q.push_back(32'(i0.read_busy1));
    obs_q.push_back(i0.read_data1);
    obs_q.push_back(32'(i2.read_busy1));
    step();
    idle();
    cnt_exp++; cnt_z0_exp++;
    push_exp("sb_busy_cleared", 32'd0);
    push_exp("sb_nb_busy_cleared", 32'd0);
    @(negedge clk);
    obs_q.push_back(32'(i0.read_busy1));
    obs_q.push_back(32'(i2.read_busy1));
    step();
    ie = 1'b1; ia = 5'd11;
    wea = 1'b1; waa = 5'd11; wda = 32'hAA;
    step();
    idle();
    cnt_exp++; cnt_z0_exp++;
    push_exp("sb_issue_wins", 32'd1);
    push_exp("sb_issue_wins_data", 32'hAA);
    @(negedge clk);
    obs_q.push_back(32'(i0.read_busy1));
    obs_q.push_back(i0.read_data1);
    step();
    wea = 1'b1; waa = 5'd11; wda = 32'hBB;
    step();
    idle();
    cnt_exp++; cnt_z0_exp++;
    push_exp("sb_final_clear", 32'd0);
    push_exp("sb_cnt", 32'(cnt_exp));
    @(negedge clk);
    obs_q.push_back(32'(i0.read_busy1));
    obs_q.push_back(32'(i0.write_count));
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (obs_q.size() == 0) begin
        n_bad++;
        $display("FAIL %s: no sample, expected %h", e.name, e.val);
      end else begin
        o = obs_q.pop_front();
        if (o !== e.val) begin
          n_bad++;
          $display("FAIL %s: got %h expected %h", e.name, o, e.val);
        end
      end
    end
  endtask

  task automatic test_wrap_and_no_bypass();
    item_t e;
    logic [31:0] o;
    @(negedge clk);
    idle();
    rst_n = 1'b0;
    #1 rst_n = 1'b1;
    cnt_exp = 0; cnt_z0_exp = 0;
    step();
    for (int i = 1; i <= 17; i++) begin
      wea = 1'b1; waa = 5'(i); wda = 32'(i) * 32'h101;
      step();
      cnt_exp++;
    end
    idle();
    push_exp("wrap_cnt4", 32'(cnt_exp % 16));
    push_exp("wrap_cnt16", 32'(cnt_exp));
    @(negedge clk);
    obs_q.push_back(32'(i3.write_count));
    obs_q.push_back(32'(i0.write_count));
    step();
    wea = 1'b1; waa = 5'd5; wda = 32'hCAFE; ra1 = 5'd5;
    push_exp("nb_same_cycle_old", 32'h505);
    push_exp("byp_same_cycle_new", 32'hCAFE);
    @(negedge clk);
    obs_q.push_back(i2.read_data1);
    obs_q.push_back(i0.read_data1);
    step();
    idle();
    cnt_exp++;
    push_exp("nb_after_edge", 32'hCAFE);
    push_exp("wrap_cnt4_next", 32'(cnt_exp % 16));
    @(negedge clk);
    obs_q.push_back(i2.read_data1);
    obs_q.push_back(32'(i3.write_count));
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (obs_q.size() == 0) begin
        n_bad++;
        $display("FAIL %s: no sample, expected %h", e.name, e.val);
      end else begin
        o = obs_q.pop_front();
        if (o !== e.val) begin
          n_bad++;
          $display("FAIL %s: got %h expected %h", e.name, o, e.val);
        end
      end
    end
  endtask

  initial begin
    n_cmp = 0; n_bad = 0;
    cnt_exp = 0; cnt_z0_exp = 0;
    ra1 = '0; ra2 = '0; waa = '0; wab = '0; ia = '0; da = '0;
    wda = '0; wdb = '0;
    wea = 1'b0; web = 1'b0; ie = 1'b0;
    rst_n = 1'b0;
    #12 rst_n = 1'b1;
    test_reset();
    test_write_read();
    test_collision();
    test_zero_reg();
    test_scoreboard();
    test_wrap_and_no_bypass();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
